sb_tracker: RTL and testbench

SB_TRACKER -- requirements
Module: sb_tracker

---
 rtl/sb_tracker_pkg.sv | 38 +++
 rtl/sb_entry.sv | 53 +++++
 rtl/sb_tracker.sv | 91 +++++++++
 tb/tb_sb_tracker.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/sb_tracker_pkg.sv
// Shared definitions for the scoreboard tracker: widths, stage bit
// positions, accept-mask constants and the operand-ready helper.
package sb_tracker_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int STAGE_W    = 3;
   localparam int SB_DATA_W  = 6;
   localparam int NUM_SLOTS  = 2;
   localparam int NUM_READS  = 4;

   // Bit index of each pipeline stage inside a one-hot position
   localparam int STAGE_EX  = 0;
   localparam int STAGE_MEM = 1;
   localparam int STAGE_WB  = 2;

   localparam logic [STAGE_W-1:0] POS_NONE  = 3'b000;
   localparam logic [STAGE_W-1:0] POS_EX    = 3'b001;
   localparam logic [STAGE_W-1:0] MASK_NONE = 3'b000;
   localparam logic [STAGE_W-1:0] MASK_ALU  = 3'b111;
   localparam logic [STAGE_W-1:0] MASK_LONG = 3'b110;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // One scoreboard entry; packs as {position, accept_mask}
   typedef struct packed {
      logic [STAGE_W-1:0] position;
      logic [STAGE_W-1:0] accept_mask;
   } sb_data_t;

   // An operand is obtainable when it already sits in the regfile or the
   // stage currently holding it is one that can forward it.
   function automatic logic operand_ready(input sb_data_t e);
      return (e.position == POS_NONE) ||
             ((e.position & e.accept_mask) != 3'b000);
   endfunction

endpackage

// File: rtl/sb_entry.sv
// Tracking state of one architectural register: where its youngest
// producer is in the pipeline and from which stages it can be forwarded.
module sb_entry
   import sb_tracker_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic                 flush,
   input  logic                 set_en,
   input  logic                 set_long,
   output logic [SB_DATA_W-1:0] entry_o,
   output logic                 busy_next_o
);

   sb_data_t entry_d;
   sb_data_t entry_q;

   // Next state: flush clears, stall holds, a new producer restarts at EX,
   // otherwise the producer advances one stage (WB retires it).
   always_comb begin
      entry_d = entry_q;
      if (flush) begin
         entry_d.position    = POS_NONE;
         entry_d.accept_mask = MASK_NONE;
      end else if (stall) begin
         entry_d = entry_q;
      end else if (set_en) begin
         entry_d.position    = POS_EX;
         entry_d.accept_mask = set_long ? MASK_LONG : MASK_ALU;
      end else begin
         entry_d.position = {entry_q.position[STAGE_MEM:STAGE_EX], 1'b0};
         if (entry_q.position[STAGE_WB]) begin
            entry_d.accept_mask = MASK_NONE;
         end else begin
            entry_d.accept_mask = entry_q.accept_mask;
         end
      end
   end

   // Entry register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         entry_q <= 6'b000000;
      end else begin
         entry_q <= entry_d;
      end
   end

   assign entry_o     = entry_q;
   assign busy_next_o = (entry_d.position != POS_NONE);

endmodule

// File: rtl/sb_tracker.sv
// Dual-issue register scoreboard: decodes issue requests into per-register
// set strobes, serves four operand lookups and counts in-flight registers.
module sb_tracker
   import sb_tracker_pkg::*;
(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 stall,
   input  logic                                 flush,
   input  logic [NUM_SLOTS-1:0]                 issue_valid,
   input  logic [NUM_SLOTS-1:0][REG_ADDR_W-1:0] issue_dest,
   input  logic [NUM_SLOTS-1:0]                 issue_long,
   input  logic [NUM_READS-1:0][REG_ADDR_W-1:0] read_addr,
   output logic [NUM_READS-1:0][SB_DATA_W-1:0]  read_data,
   output logic [NUM_READS-1:0]                 read_ready,
   output logic [5:0]                           inflight_cnt
);

   logic [SB_DATA_W-1:0] entry_s     [NUM_REGS];
   logic                 busy_next_s [NUM_REGS];
   logic                 set_en_s    [NUM_REGS];
   logic                 set_long_s  [NUM_REGS];
   logic [5:0]           cnt_d;
   logic [5:0]           cnt_q;

   // Issue decode: slot 1 is younger, so it wins when both name the same register
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         set_en_s[r]   = 1'b0;
         set_long_s[r] = 1'b0;
         if (r == 0) begin
            set_en_s[r]   = 1'b0;
            set_long_s[r] = 1'b0;
         end else if (issue_valid[1] && (issue_dest[1] == reg_addr_t'(r))) begin
            set_en_s[r]   = 1'b1;
            set_long_s[r] = issue_long[1];
         end else if (issue_valid[0] && (issue_dest[0] == reg_addr_t'(r))) begin
            set_en_s[r]   = 1'b1;
            set_long_s[r] = issue_long[0];
         end else begin
            set_en_s[r]   = 1'b0;
            set_long_s[r] = 1'b0;
         end
      end
   end

   // r0 is hard-wired: never in flight
   assign entry_s[0]     = 6'b000000;
   assign busy_next_s[0] = 1'b0;

   for (genvar g = 1; g < NUM_REGS; g++) begin : g_entry
      sb_entry u_entry (
         .clk         (clk),
         .rst         (rst),
         .stall       (stall),
         .flush       (flush),
         .set_en      (set_en_s[g]),
         .set_long    (set_long_s[g]),
         .entry_o     (entry_s[g]),
         .busy_next_o (busy_next_s[g])
      );
   end

   // Operand lookups from current state only
   always_comb begin
      for (int k = 0; k < NUM_READS; k++) begin
         read_data[k]  = entry_s[read_addr[k]];
         read_ready[k] = operand_ready(sb_data_t'(entry_s[read_addr[k]]));
      end
   end

   // Population count over next-state entries so the registered count lines up with read_data
   always_comb begin
      cnt_d = 6'd0;
      for (int r = 0; r < NUM_REGS; r++) begin
         cnt_d = cnt_d + {5'd0, busy_next_s[r]};
      end
   end

   // In-flight count register with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 6'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign inflight_cnt = cnt_q;

endmodule

// File: tb/tb_sb_tracker.sv
// Directed bench for sb_tracker: the stimulus process queues the expected
// lookup results for each cycle, a monitor pops and compares them.
module tb_sb_tracker;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             stall = 1'b0;
   logic             flush = 1'b0;
   logic [1:0]       issue_valid = 2'b00;
   logic [1:0][4:0]  issue_dest = 10'd0;
   logic [1:0]       issue_long = 2'b00;
   logic [3:0][4:0]  read_addr = 20'd0;
   logic [3:0][5:0]  read_data;
   logic [3:0]       read_ready;
   logic [5:0]       inflight_cnt;

   typedef struct packed {
      logic [23:0] data;
      logic [3:0]  rdy;
      logic [5:0]  cnt;
   } exp_t;

   exp_t  exp_q [$];
   string nm_q  [$];
   logic  chk_valid = 1'b0;
   int    tests = 0;
   int    fails = 0;

   localparam logic [5:0] Z = 6'b000000;

   sb_tracker dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .issue_valid  (issue_valid),
      .issue_dest   (issue_dest),
      .issue_long   (issue_long),
      .read_addr    (read_addr),
      .read_data    (read_data),
      .read_ready   (read_ready),
      .inflight_cnt (inflight_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] d(input logic [2:0] p, input logic [2:0] m);
      return {p, m};
   endfunction

   // One cycle: drive inputs just after the edge and queue what the current
   // state must show on the lookups during this cycle.
   task automatic step(input logic r, input logic s, input logic f,
                       input logic [1:0] v, input logic [4:0] d0, input logic [4:0] d1,
                       input logic [1:0] lg,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] a3,
                       input logic chk,
                       input logic [5:0] e0, input logic [5:0] e1,
                       input logic [5:0] e2, input logic [5:0] e3,
                       input logic [3:0] er, input logic [5:0] ec,
                       input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst         = r;
      stall       = s;
      flush       = f;
      issue_valid = v;
      issue_dest  = {d1, d0};
      issue_long  = lg;
      read_addr   = {a3, a2, a1, a0};
      if (chk) begin
         e.data = {e3, e2, e1, e0};
         e.rdy  = er;
         e.cnt  = ec;
         exp_q.push_back(e);
         nm_q.push_back(nm);
      end
      chk_valid = chk;
   endtask

   // Monitor: compares the DUT outputs against the oldest queued expectation
   always @(negedge clk) begin
      if (chk_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL no_expectation: DUT presented data %h with empty queue", read_data);
         end else begin
            exp_t  e;
            string nm;
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            tests++;
            if (read_data !== e.data) begin
               fails++;
               $display("FAIL %s.data: got %h expected %h", nm, read_data, e.data);
            end
            tests++;
            if (read_ready !== e.rdy) begin
               fails++;
               $display("FAIL %s.ready: got %b expected %b", nm, read_ready, e.rdy);
            end
            tests++;
            if (inflight_cnt !== e.cnt) begin
               fails++;
               $display("FAIL %s.cnt: got %0d expected %0d", nm, inflight_cnt, e.cnt);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "timeout");
   end

   // Directed stimulus
   initial begin
      step(1'b1,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,
           Z, Z, Z, Z, 4'b1111, 6'd0, "rst0");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd5, 5'd7, 5'd0, 5'd31, 1'b1,
           Z, Z, Z, Z, 4'b1111, 6'd0, "reset_state");
      // ALU producer r5 walks EX -> MEM -> WB -> regfile
      step(1'b0,1'b0,1'b0, 2'b01, 5'd5, 5'd0, 2'b00, 5'd5, 5'd5, 5'd0, 5'd0, 1'b1,
           Z, Z, Z, Z, 4'b1111, 6'd0, "r5_pre");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd5, 5'd5, 5'd0, 5'd0, 1'b1,
           d(3'b001,3'b111), d(3'b001,3'b111), Z, Z, 4'b1111, 6'd1, "r5_ex");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd5, 5'd5, 5'd0, 5'd0, 1'b1,
           d(3'b010,3'b111), d(3'b010,3'b111), Z, Z, 4'b1111, 6'd1, "r5_mem");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd5, 5'd5, 5'd0, 5'd0, 1'b1,
           d(3'b100,3'b111), d(3'b100,3'b111), Z, Z, 4'b1111, 6'd1, "r5_wb");
      // Long producer r7: not forwardable from EX
      step(1'b0,1'b0,1'b0, 2'b01, 5'd7, 5'd0, 2'b01, 5'd5, 5'd7, 5'd0, 5'd0, 1'b1,
           Z, Z, Z, Z, 4'b1111, 6'd0, "r5_done");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd7, 5'd7, 5'd0, 5'd0, 1'b1,
           d(3'b001,3'b110), d(3'b001,3'b110), Z, Z, 4'b1100, 6'd1, "r7_ex");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd7, 5'd7, 5'd0, 5'd0, 1'b1,
           d(3'b010,3'b110), d(3'b010,3'b110), Z, Z, 4'b1111, 6'd1, "r7_mem");
      // Both slots target r9: slot 1 (long) wins
      step(1'b0,1'b0,1'b0, 2'b11, 5'd9, 5'd9, 2'b10, 5'd7, 5'd9, 5'd0, 5'd0, 1'b1,
           d(3'b100,3'b110), Z, Z, Z, 4'b1111, 6'd1, "r7_wb");
      step(1'b0,1'b0,1'b0, 2'b10, 5'd0, 5'd3, 2'b00, 5'd7, 5'd9, 5'd9, 5'd0, 1'b1,
           Z, d(3'b001,3'b110), d(3'b001,3'b110), Z, 4'b1001, 6'd1, "r9_slot1");
      // Stall two cycles: positions hold, issue of r4 ignored
      step(1'b0,1'b1,1'b0, 2'b01, 5'd4, 5'd0, 2'b00, 5'd3, 5'd9, 5'd4, 5'd0, 1'b1,
           d(3'b001,3'b111), d(3'b010,3'b110), Z, Z, 4'b1111, 6'd2, "stall_a");
      step(1'b0,1'b1,1'b0, 2'b01, 5'd4, 5'd0, 2'b00, 5'd3, 5'd9, 5'd4, 5'd0, 1'b1,
           d(3'b001,3'b111), d(3'b010,3'b110), Z, Z, 4'b1111, 6'd2, "stall_b");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd3, 5'd9, 5'd4, 5'd0, 1'b1,
           d(3'b001,3'b111), d(3'b010,3'b110), Z, Z, 4'b1111, 6'd2, "stall_c");
      step(1'b0,1'b0,1'b0, 2'b11, 5'd1, 5'd2, 2'b10, 5'd3, 5'd9, 5'd4, 5'd0, 1'b1,
           d(3'b010,3'b111), d(3'b100,3'b110), Z, Z, 4'b1111, 6'd2, "resume");
      // Flush together with an issue of r6: everything clears
      step(1'b0,1'b0,1'b1, 2'b01, 5'd6, 5'd0, 2'b00, 5'd1, 5'd2, 5'd3, 5'd9, 1'b1,
           d(3'b001,3'b111), d(3'b001,3'b110), d(3'b100,3'b111), Z, 4'b1101, 6'd3, "pre_flush");
      step(1'b0,1'b0,1'b0, 2'b11, 5'd0, 5'd31, 2'b10, 5'd1, 5'd2, 5'd6, 5'd3, 1'b1,
           Z, Z, Z, Z, 4'b1111, 6'd0, "flushed");
      // r0 never tracked; reset mid-flight beats an issue of r5
      step(1'b1,1'b0,1'b0, 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 5'd31, 5'd0, 5'd31, 1'b1,
           Z, d(3'b001,3'b110), Z, d(3'b001,3'b110), 4'b0101, 6'd1, "r31_r0");
      step(1'b0,1'b0,1'b0, 2'b01, 5'd12, 5'd0, 2'b00, 5'd0, 5'd31, 5'd5, 5'd0, 1'b1,
           Z, Z, Z, Z, 4'b1111, 6'd0, "mid_reset");
      // WAW: in-flight r12 re-issued as long restarts at EX with the new mask
      step(1'b0,1'b0,1'b0, 2'b01, 5'd12, 5'd0, 2'b01, 5'd12, 5'd12, 5'd0, 5'd0, 1'b1,
           d(3'b001,3'b111), d(3'b001,3'b111), Z, Z, 4'b1111, 6'd1, "waw_a");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd12, 5'd12, 5'd0, 5'd0, 1'b1,
           d(3'b001,3'b110), d(3'b001,3'b110), Z, Z, 4'b1100, 6'd1, "waw_b");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd12, 5'd12, 5'd0, 5'd0, 1'b1,
           d(3'b010,3'b110), d(3'b010,3'b110), Z, Z, 4'b1111, 6'd1, "waw_c");
      step(1'b0,1'b0,1'b0, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0,
           Z, Z, Z, Z, 4'b1111, 6'd0, "drain");
      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL queue_empty: got %0d pending expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
